// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RISC-V immediate generator with branch target and skid buffer
// Decodes format and immediate, adds PC, and queues results behind a valid/ready handshake.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
  } entry_t;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [31:0]     imm32;
  logic [2:0]      fmt;
  logic            illegal;
  logic [XLEN-1:0] imm_x;
  entry_t          new_entry;

  always_comb begin
    imm32   = '0;
    fmt     = FMT_ILL;
    illegal = 1'b0;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0011011: begin
        fmt   = FMT_I;
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        fmt   = FMT_S;
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        fmt   = FMT_B;
        imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        fmt   = FMT_U;
        imm32 = {in_instr[31:12], 12'h000};
      end
      7'b1101111: begin
        fmt   = FMT_J;
        imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110011, 7'b0111011, 7'b0001111, 7'b1110011: begin
        fmt   = FMT_R;
        imm32 = '0;
      end
      default: begin
        fmt     = FMT_ILL;
        illegal = 1'b1;
        imm32   = '0;
      end
    endcase
  end

  // Every 32-bit immediate (U included) extends from its bit 31 on RV64.
  generate
    if (XLEN == 64) begin : g_sext64
      assign imm_x = {{32{imm32[31]}}, imm32};
    end else begin : g_sext32
      assign imm_x = imm32;
    end
  endgenerate

  always_comb begin
    new_entry         = '0;
    new_entry.imm     = imm_x;
    new_entry.fmt     = fmt;
    new_entry.illegal = illegal;
    new_entry.target  = in_pc + imm_x;
    new_entry.pc      = in_pc;
  end

  logic [1:0] count_q, count_d;
  entry_t     head_q, head_d;
  entry_t     second_q, second_d;
  logic       push, pop;

  assign out_valid = (count_q != 2'd0);

  generate
    if (DEPTH == 1) begin : g_depth1
      assign in_ready = !out_valid || out_ready;
    end else begin : g_depth2
      assign in_ready = (count_q != 2'd2);
    end
  endgenerate

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    count_d  = count_q;
    head_d   = head_q;
    second_d = second_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = new_entry;
        end else begin
          second_d = new_entry;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // Head register is left untouched when draining the last entry.
        if (count_q == 2'd2) begin
          head_d = second_q;
        end
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          head_d   = second_q;
          second_d = new_entry;
        end else begin
          head_d = new_entry;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      head_q   <= '0;
      second_q <= '0;
    end else begin
      count_q  <= count_d;
      head_q   <= head_d;
      second_q <= second_d;
    end
  end

  assign out_imm     = head_q.imm;
  assign out_fmt     = head_q.fmt;
  assign out_illegal = head_q.illegal;
  assign out_target  = head_q.target;
  assign out_pc      = head_q.pc;

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the RISC-V datapath. Decodes the instruction format, sign-extends the immediate to XLEN and computes the PC-relative branch/jump target. Results are buffered behind a valid/ready handshake so the block sits between fetch and execute as a registered decode slice with a 2-entry skid buffer.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64. Immediate and PC/target widths.
DEPTH, 2, output buffer entries; legal values 1 or 2. With 1, in_ready is combinationally equal to (!out_valid || out_ready).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  upstream instruction valid
in_ready  out  1  block can accept an instruction this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  PC of in_instr
out_valid  out  1  head entry valid
out_ready  in  1  downstream accepts the head entry
out_imm  out  XLEN  sign-extended immediate
out_fmt  out  3  0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal
out_illegal  out  1  opcode not recognised
out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN
out_pc  out  XLEN  PC of the head entry

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Opcode decode, in_instr[6:0]:
  - I format (fmt 1): 0000011, 0010011, 1100111, 0011011. Immediate is {sext ins[31:20]}.
  - S format (fmt 2): 0100011. Immediate is {sext ins[31:25], ins[11:7]}.
  - B format (fmt 3): 1100011. Immediate is {sext ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}.
  - U format (fmt 4): 0110111, 0010111. Immediate is {ins[31:12], 12'h000}, sign-extended from bit 31 when XLEN=64.
  - J format (fmt 5): 1101111. Immediate is {sext ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}.
  - R/none (fmt 0): 0110011, 0111011, 0001111, 1110011. Immediate is 0.
  - Any other opcode: fmt 7, out_illegal=1, out_imm=0. The output is never X or Z.
- out_target is computed for every entry, regardless of format. Downstream qualifies it with out_fmt.
- Handshake:
  - A push occurs when in_valid && in_ready. A pop occurs when out_valid && out_ready.
  - Latency: an instruction pushed in cycle N appears at the head in cycle N+1 at the earliest.
  - No combinational path from in_* to out_*.
- Buffer (DEPTH=2):
  - Count is 0..2. in_ready = (count<2); it depends only on state, not on out_ready.
  - Push and pop in the same cycle leave count unchanged and keep FIFO order.
  - Push when empty loads the head.
  - Pop with count=2 promotes the second entry to the head.
  - Push while full is impossible because in_ready=0, so in_valid is ignored.
  - Pop while empty is ignored.
- Stall: while out_valid && !out_ready, every out_* signal holds stable.
- Reset:
  - Count becomes 0 and out_valid becomes 0.
  - out_imm, out_fmt, out_illegal, out_target and out_pc all become 0.
  - in_ready is 1 in the first cycle after reset.
  - Reset mid-operation discards all buffered entries. A push presented in the reset cycle is dropped.

Test Plan:
- XLEN=32: push 0xFFF00093 (addi x1,x0,-1) at pc 0x0 with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_illegal=0.
- Push 0xFE112E23 (sw x1,-4(x2)) -> out_imm=0xFFFFFFFC, out_fmt=2. Push 0xFE000CE3 (beq -8) at pc 0x100 -> out_imm=0xFFFFFFF8, out_fmt=3, out_target=0x000000F8.
- Push 0x123450B7 (lui) -> out_imm=0x12345000, fmt 4. Under XLEN=64, push 0x800000B7 -> out_imm=0xFFFFFFFF80000000, and addi -1 gives 0xFFFFFFFFFFFFFFFF.
- Push 0x00000000 -> out_fmt=7, out_illegal=1, out_imm=0.
- Hold out_ready=0 and offer 3 back-to-back instructions -> in_ready=0 after the 2nd push, the 3rd is held upstream, and outputs stay stable. Release out_ready -> all 3 emerge in order, with simultaneous push/pop sustaining 1 per cycle.
- With 2 entries buffered, assert rst for 1 cycle while in_valid=1 -> out_valid=0, all outputs 0, in_ready=1, and no stale entry emerges afterwards.
